// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that puts one requester at a time
// onto a simple read/write memory bus, with a bus-wait timeout.
//
// Ports:
//   clk, rst           clock, async active-low reset
//   req_valid/we       per-channel request strobe and write flag
//   req_addr/wdata     packed per-channel address and write data
//   req_ready          one-hot grant pulse
//   resp_valid         one-hot completion pulse
//   resp_data/err      last read data, timeout flag (with resp_valid)
//   address_out        bus address (0 when not on the bus)
//   data_out_BUS       bus write data (0 when not on the bus)
//   bus_re/bus_we      bus read/write strobes
//   bus_full           bus completion
//   data_in_BUS        bus read data
module mem_bus_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_valid,
    input  logic [NCH-1:0]        req_we,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    output logic [NCH-1:0]        req_ready,
    output logic [NCH-1:0]        resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     address_out,
    output logic [DATA_W-1:0]     data_out_BUS,
    output logic                  bus_re,
    output logic                  bus_we,
    input  logic                  bus_full,
    input  logic [DATA_W-1:0]     data_in_BUS
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_R = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (CNT_R > 0) ? CNT_R : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  g_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              err_q;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    int                cand;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = int'(rr_ptr_q) + 1 + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!gnt_found && req_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_full || cnt_q == CNT_MAX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are latched at grant so later req_* changes are
    // invisible to the transaction on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= PTR_W'(NCH - 1);
            g_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        g_q      <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        addr_q   <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                        wdata_q  <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                        we_q     <= req_we[gnt_idx];
                        cnt_q    <= '0;
                    end
                end
                S_BUS: begin
                    // Completion beats a timeout landing in the same cycle.
                    if (bus_full) begin
                        if (!we_q) begin
                            resp_data_q <= data_in_BUS;
                        end
                        err_q <= 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        resp_err     = 1'b0;
        address_out  = '0;
        data_out_BUS = '0;
        bus_re       = 1'b0;
        bus_we       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Gate with reset so no grant escapes while held in reset.
                if (gnt_found && rst) begin
                    req_ready[gnt_idx] = 1'b1;
                end
            end
            S_BUS: begin
                address_out  = addr_q;
                data_out_BUS = wdata_q;
                bus_re       = !we_q;
                bus_we       = we_q;
            end
            S_DONE: begin
                resp_valid[g_q] = 1'b1;
                resp_err        = err_q;
            end
            default: ;
        endcase
    end

    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors for mem_bus_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked after that.
module tb_mem_bus_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NCH = 2;
    localparam int TO  = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic [AW-1:0]     address_out;
    logic [DW-1:0]     data_out_BUS;
    logic              bus_re;
    logic              bus_we;
    logic              bus_full;
    logic [DW-1:0]     data_in_BUS;

    int nvec = 0;
    int nerr = 0;
    int nhigh;
    logic [NCH-1:0] seen;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .NCH(NCH), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .address_out(address_out),
        .data_out_BUS(data_out_BUS),
        .bus_re(bus_re),
        .bus_we(bus_we),
        .bus_full(bus_full),
        .data_in_BUS(data_in_BUS)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        bus_full    = 1'b0;
        data_in_BUS = '0;

        // reset state, with requests present
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rvalid", resp_valid, 2'b00);
        check("rst_addr", address_out, 0);
        check("rst_wdata", data_out_BUS, 0);
        check("rst_strobe", {bus_re, bus_we}, 2'b00);
        check("rst_rdata", resp_data, 0);
        check("rst_err", resp_err, 0);
        req_valid = '0;
        rst = 1'b1;
        tick;

        // round robin with both held, minimum latency
        req_valid = 2'b11;
        req_we    = 2'b00;
        #1;
        check("rr_g0", req_ready, 2'b01);
        tick;
        check("rr_bus_re", {bus_re, bus_we}, 2'b10);
        check("rr_bus_ready", req_ready, 2'b00);
        bus_full    = 1'b1;
        data_in_BUS = 32'h11;
        tick;
        check("rr_done0", resp_valid, 2'b01);
        check("rr_data0", resp_data, 32'h11);
        bus_full = 1'b0;
        tick;
        check("rr_g1", req_ready, 2'b10);
        tick;
        bus_full    = 1'b1;
        data_in_BUS = 32'h22;
        tick;
        check("rr_done1", resp_valid, 2'b10);
        bus_full = 1'b0;
        tick;
        check("rr_g2", req_ready, 2'b01);
        tick;
        bus_full    = 1'b1;
        data_in_BUS = 32'h33;
        tick;
        bus_full  = 1'b0;
        req_valid = '0;
        tick;

        // read ch0 addr 0x4, completion in third bus cycle
        req_valid       = 2'b01;
        req_addr[0+:AW] = 32'h4;
        req_we          = 2'b00;
        #1;
        check("rd_grant", req_ready, 2'b01);
        tick;
        req_valid = '0;
        #1;
        check("rd_addr", address_out, 32'h4);
        check("rd_re1", {bus_re, bus_we}, 2'b10);
        tick;
        check("rd_re2", {bus_re, bus_we}, 2'b10);
        tick;
        check("rd_re3", {bus_re, bus_we}, 2'b10);
        bus_full    = 1'b1;
        data_in_BUS = 32'h1;
        tick;
        bus_full = 1'b0;
        #1;
        check("rd_valid", resp_valid, 2'b01);
        check("rd_data", resp_data, 32'h1);
        check("rd_err", resp_err, 0);
        check("rd_strobe_off", {bus_re, bus_we}, 2'b00);
        check("rd_addr_off", address_out, 0);
        tick;
        check("rd_pulse", resp_valid, 2'b00);

        // write ch1; request fields change after grant
        req_valid          = 2'b10;
        req_we             = 2'b10;
        req_addr[AW+:AW]   = 32'h10;
        req_wdata[DW+:DW]  = 32'd30;
        #1;
        check("wr_grant", req_ready, 2'b10);
        tick;
        req_valid         = '0;
        req_we            = '0;
        req_addr[AW+:AW]  = 32'h99;
        req_wdata[DW+:DW] = 32'd77;
        #1;
        check("wr_data", data_out_BUS, 32'd30);
        check("wr_strobe", {bus_re, bus_we}, 2'b01);
        check("wr_addr", address_out, 32'h10);
        tick;
        check("wr_hold_addr", address_out, 32'h10);
        check("wr_hold_data", data_out_BUS, 32'd30);
        check("wr_hold_strobe", {bus_re, bus_we}, 2'b01);
        bus_full    = 1'b1;
        data_in_BUS = 32'hAAAA5555;
        tick;
        bus_full = 1'b0;
        #1;
        check("wr_valid", resp_valid, 2'b10);
        check("wr_rdata", resp_data, 32'h1);
        check("wr_err", resp_err, 0);
        check("wr_data_off", data_out_BUS, 0);
        tick;

        // bus_full while idle is ignored
        bus_full    = 1'b1;
        data_in_BUS = 32'hDEADBEEF;
        tick;
        check("idle_bf_v0", resp_valid, 2'b00);
        tick;
        check("idle_bf_v1", resp_valid, 2'b00);
        check("idle_bf_data", resp_data, 32'h1);
        check("idle_bf_strobe", {bus_re, bus_we}, 2'b00);
        bus_full = 1'b0;
        tick;

        // timeout: strobe held TIMEOUT+1 cycles, then error
        req_valid       = 2'b01;
        req_addr[0+:AW] = 32'h20;
        req_we          = 2'b00;
        #1;
        check("to_grant", req_ready, 2'b01);
        tick;
        req_valid = '0;
        nhigh = 0;
        for (int i = 0; i <= TO; i++) begin
            if (bus_re) nhigh++;
            tick;
        end
        check("to_cycles", nhigh, TO + 1);
        check("to_valid", resp_valid, 2'b01);
        check("to_err", resp_err, 1);
        check("to_data", resp_data, 32'h1);
        check("to_strobe_off", {bus_re, bus_we}, 2'b00);
        tick;

        // bus_full in the timeout cycle completes normally
        req_valid = 2'b01;
        #1;
        check("tw_grant", req_ready, 2'b01);
        tick;
        req_valid = '0;
        for (int i = 0; i < TO; i++) begin
            tick;
        end
        check("tw_re", bus_re, 1);
        bus_full    = 1'b1;
        data_in_BUS = 32'h55;
        tick;
        bus_full = 1'b0;
        #1;
        check("tw_valid", resp_valid, 2'b01);
        check("tw_err", resp_err, 0);
        check("tw_data", resp_data, 32'h55);
        tick;

        // reset in the middle of a bus transaction
        req_valid        = 2'b10;
        req_we           = 2'b00;
        req_addr[AW+:AW] = 32'h40;
        #1;
        check("rs_grant1", req_ready, 2'b10);
        tick;
        req_valid = '0;
        #1;
        check("rs_re", bus_re, 1);
        #1;
        rst = 1'b0;
        #1;
        check("rs_addr", address_out, 0);
        check("rs_strobe", {bus_re, bus_we}, 2'b00);
        check("rs_rdata", resp_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            seen = seen | resp_valid;
        end
        check("rs_no_valid", seen, 2'b00);
        req_valid = 2'b11;
        #1;
        check("rs_grant_ch0", req_ready, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
